// File: rtl/bin_a_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// overflow saturation to all nines and a leading-zero blanking mask.
module bin_a_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_ZERO = ~DIGITS'(1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t           r_state;
  logic [BIN_W-1:0] r_shift;
  logic [BCD_W-1:0] r_work;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic [BCD_W-1:0]  w_adj;
  logic [BCD_W-1:0]  w_shifted;
  logic [BCD_W-1:0]  w_nines;
  logic [BCD_W-1:0]  w_final;
  logic [DIGITS-1:0] w_blank;
  logic              w_ovf_now;
  logic              w_last;

  // Per-digit +3 adjust; each digit is at most 9 here, so the 4-bit add never wraps.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] w_digit;
    assign w_digit              = r_work[4*gi +: 4];
    assign w_adj[4*gi +: 4]     = (w_digit >= 4'd5) ? (w_digit + 4'd3) : w_digit;
    assign w_nines[4*gi +: 4]   = 4'd9;
  end

  assign w_shifted = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
  assign w_ovf_now = r_ovf | w_adj[BCD_W-1];
  assign w_final   = w_ovf_now ? w_nines : w_shifted;
  assign w_last    = (r_cnt == CNT_W'(BIN_W - 1));

  // A digit is blanked when it and every digit above it are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_lsd
      assign w_blank[gi] = 1'b0;
    end else begin : g_upper
      assign w_blank[gi] = ~|w_final[BCD_W-1:4*gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_work  <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
      blank   <= BLANK_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_shift <= bin;
            r_work  <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_work  <= w_shifted;
          r_shift <= r_shift << 1;
          r_ovf   <= w_ovf_now;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            bcd     <= w_final;
            ovf     <= w_ovf_now;
            blank   <= w_blank;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_a_bcd_seq.sv
// Directed testbench for bin_a_bcd_seq: default 14-bit/4-digit instance plus
// a 10-bit/3-digit instance swept over its whole input range.
module tb_bin_a_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;
  logic [3:0]  blank;

  logic        s_rst_n;
  logic        s_start;
  logic [9:0]  s_bin;
  logic        s_busy;
  logic        s_done;
  logic [11:0] s_bcd;
  logic        s_ovf;
  logic [2:0]  s_blank;

  int n_checks = 0;
  int n_pass   = 0;

  bin_a_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .blank(blank)
  );

  bin_a_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .bin(s_bin),
    .busy(s_busy), .done(s_done), .bcd(s_bcd), .ovf(s_ovf), .blank(s_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start a conversion and wait (bounded) for done; returns latency and busy-cycle count.
  task automatic do_conv(input logic [13:0] val, output int lat, output int busy_cnt);
    start = 1'b1;
    bin   = val;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    $display("conv bin=%0d lat=%0d bcd=%h ovf=%0b blank=%b", val, lat, bcd, ovf, blank);
  endtask

  task automatic do_conv_s(input logic [9:0] val, output int lat);
    s_start = 1'b1;
    s_bin   = val;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat     = 0;
    while (!s_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_rst_n = 1'b0; start = 1'b0; s_start = 1'b0; bin = '0; s_bin = '0;
    repeat (2) @(posedge clk);
    #1;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++;
    if (bcd !== 16'h0000) $display("FAIL reset_bcd: got %h expected 0000", bcd); else n_pass++;
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else n_pass++;
    n_checks++;
    if (blank !== 4'b1110) $display("FAIL reset_blank: got %b expected 1110", blank); else n_pass++;
    n_checks++;
    if (s_blank !== 3'b110) $display("FAIL reset_blank_s: got %b expected 110", s_blank); else n_pass++;
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1; s_rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_max_value();
    int lat, bc;
    do_conv(14'd9999, lat, bc);
    if (lat !== 14) $display("FAIL 9999_latency: got %0d expected 14", lat); else n_pass++;
    n_checks++;
    if (bc !== 14) $display("FAIL 9999_busy_cycles: got %0d expected 14", bc); else n_pass++;
    n_checks++;
    if (bcd !== 16'h9999) $display("FAIL 9999_bcd: got %h expected 9999", bcd); else n_pass++;
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL 9999_ovf: got %b expected 0", ovf); else n_pass++;
    n_checks++;
    if (blank !== 4'b0000) $display("FAIL 9999_blank: got %b expected 0000", blank); else n_pass++;
    n_checks++;
    @(posedge clk); #1;
    if (done !== 1'b0) $display("FAIL 9999_done_width: got %b expected 0", done); else n_pass++;
    n_checks++;
    if (bcd !== 16'h9999) $display("FAIL 9999_hold: got %h expected 9999", bcd); else n_pass++;
    n_checks++;
  endtask

  task automatic test_blanking();
    int lat, bc;
    do_conv(14'd305, lat, bc);
    if (bcd !== 16'h0305) $display("FAIL 305_bcd: got %h expected 0305", bcd); else n_pass++;
    n_checks++;
    if (blank !== 4'b1000) $display("FAIL 305_blank: got %b expected 1000", blank); else n_pass++;
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL 305_ovf: got %b expected 0", ovf); else n_pass++;
    n_checks++;
    @(posedge clk); #1;
    do_conv(14'd0, lat, bc);
    if (bcd !== 16'h0000) $display("FAIL 0_bcd: got %h expected 0000", bcd); else n_pass++;
    n_checks++;
    if (blank !== 4'b1110) $display("FAIL 0_blank: got %b expected 1110", blank); else n_pass++;
    n_checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat, bc;
    logic [13:0] vals [2];
    vals[0] = 14'd10000;
    vals[1] = 14'd16383;
    for (int i = 0; i < 2; i++) begin
      do_conv(vals[i], lat, bc);
      if (bcd !== 16'h9999) $display("FAIL ovf_bcd_%0d: got %h expected 9999", vals[i], bcd); else n_pass++;
      n_checks++;
      if (ovf !== 1'b1) $display("FAIL ovf_flag_%0d: got %b expected 1", vals[i], ovf); else n_pass++;
      n_checks++;
      @(posedge clk); #1;
      if (ovf !== 1'b1) $display("FAIL ovf_hold_%0d: got %b expected 1", vals[i], ovf); else n_pass++;
      n_checks++;
    end
    do_conv(14'd42, lat, bc);
    if (bcd !== 16'h0042) $display("FAIL 42_bcd: got %h expected 0042", bcd); else n_pass++;
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL 42_ovf: got %b expected 0", ovf); else n_pass++;
    n_checks++;
    if (blank !== 4'b1100) $display("FAIL 42_blank: got %b expected 1100", blank); else n_pass++;
    n_checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    start = 1'b1;
    bin   = 14'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 3 || cyc == 10) begin
        start = 1'b1;
        bin   = 14'd77;
      end else begin
        start = 1'b0;
      end
      if (done) dones++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    $display("busy-start test: dones=%0d bcd=%h", dones, bcd);
    if (dones !== 1) $display("FAIL busy_start_dones: got %0d expected 1", dones); else n_pass++;
    n_checks++;
    if (bcd !== 16'h1234) $display("FAIL busy_start_bcd: got %h expected 1234", bcd); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_start_idle: got %b expected 0", busy); else n_pass++;
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_conv(14'd321, lat, bc);
    if (bcd !== 16'h0321) $display("FAIL b2b_first_bcd: got %h expected 0321", bcd); else n_pass++;
    n_checks++;
    // Still inside the done cycle: the next start must be accepted.
    do_conv(14'd8, lat, bc);
    if (lat !== 14) $display("FAIL b2b_latency: got %0d expected 14", lat); else n_pass++;
    n_checks++;
    if (bcd !== 16'h0008) $display("FAIL b2b_bcd: got %h expected 0008", bcd); else n_pass++;
    n_checks++;
    if (blank !== 4'b1110) $display("FAIL b2b_blank: got %b expected 1110", blank); else n_pass++;
    n_checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int dones = 0;
    start = 1'b1;
    bin   = 14'd5000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", done); else n_pass++;
    n_checks++;
    if (bcd !== 16'h0000) $display("FAIL midrst_bcd: got %h expected 0000", bcd); else n_pass++;
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL midrst_ovf: got %b expected 0", ovf); else n_pass++;
    n_checks++;
    if (blank !== 4'b1110) $display("FAIL midrst_blank: got %b expected 1110", blank); else n_pass++;
    n_checks++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    $display("reset-mid test: dones after abort=%0d", dones);
    if (dones !== 0) $display("FAIL midrst_no_done: got %0d expected 0", dones); else n_pass++;
    n_checks++;
    do_conv(14'd5000, lat, bc);
    if (bcd !== 16'h5000) $display("FAIL midrst_restart_bcd: got %h expected 5000", bcd); else n_pass++;
    n_checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat;
    int errs = 0;
    logic [11:0] exp_bcd;
    logic [2:0]  exp_blank;
    logic        exp_ovf;
    logic [3:0]  d0, d1, d2;
    for (int v = 0; v < 1024; v++) begin
      if (v > 999) begin
        d2 = 4'd9; d1 = 4'd9; d0 = 4'd9;
        exp_ovf = 1'b1;
      end else begin
        d2 = 4'(v / 100);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        exp_ovf = 1'b0;
      end
      exp_bcd   = {d2, d1, d0};
      exp_blank = {d2 == 4'd0, (d2 == 4'd0) && (d1 == 4'd0), 1'b0};
      do_conv_s(10'(v), lat);
      if (lat !== 10) begin
        $display("FAIL sweep_latency_%0d: got %0d expected 10", v, lat);
        errs++;
      end else n_pass++;
      n_checks++;
      if (s_bcd !== exp_bcd) begin
        $display("FAIL sweep_bcd_%0d: got %h expected %h", v, s_bcd, exp_bcd);
        errs++;
      end else n_pass++;
      n_checks++;
      if (s_ovf !== exp_ovf) begin
        $display("FAIL sweep_ovf_%0d: got %b expected %b", v, s_ovf, exp_ovf);
        errs++;
      end else n_pass++;
      n_checks++;
      if (s_blank !== exp_blank) begin
        $display("FAIL sweep_blank_%0d: got %b expected %b", v, s_blank, exp_blank);
        errs++;
      end else n_pass++;
      n_checks++;
    end
    $display("sweep 0..1023 on 10-bit/3-digit instance: %0d discrepancies", errs);
  endtask

  initial begin
    test_reset();
    test_max_value();
    test_blanking();
    test_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bin_a_bcd_seq.md
Name: bin_a_bcd_seq

Overview:
- Parametrised, multi-cycle binary-to-BCD converter for score/record display paths.
- Converts BIN_W bits to DIGITS packed BCD digits with the shift-add-3 algorithm, one bit per clock.
- Uses a start/busy/done handshake and adds saturation on overflow plus a leading-zero blanking mask for the 7-segment drivers.
- Sits between the score counter and the display multiplexer.

Parameters:
- BIN_W, 14, binary input width; legal range 1..32.
- DIGITS, 4, number of BCD output digits; legal range 1..10.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to convert; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd, ovf and blank are updated.
- bcd  output  4*DIGITS  packed result; digit 0 is bits [3:0] and is least significant.
- ovf  output  1  bin exceeded 10^DIGITS−1; held with bcd.
- blank  output  DIGITS  bit i=1 means digit i is a leading zero; bit 0 is always 0.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state to IDLE; busy=0, done=0;
  - bcd=0, ovf=0;
  - blank = all ones except bit 0, i.e. blanking as for value 0;
  - internal shift, BCD and counter registers to 0.
- FSM states: IDLE and SHIFT.
- IDLE, start=1 at edge E0:
  - latch bin into the shift register;
  - clear the working BCD register, the sticky overflow flag and the bit counter;
  - go to SHIFT; busy=1 after E0.
- IDLE, start=0: remain in IDLE; all outputs hold.
- SHIFT, each edge:
  1. every working digit ≥5 gets +3 (4-bit add, no carry across digits);
  2. {bcd_work, shift_reg} shifts left by 1, the binary MSB entering digit 0 LSB;
  3. the bit shifted out of the top digit MSB is ORed into the sticky overflow flag;
  4. the counter increments.
- Transition out of SHIFT happens on the edge performing shift number BIN_W, i.e. edge E0+BIN_W. That same edge:
  - loads bcd with the shifted result, or with all digits 9 (0x9…9) if the overflow flag is set or set on this shift;
  - loads ovf with that overflow value;
  - loads blank, computed from the final bcd value;
  - sets done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency: done is high in the cycle after edge E0+BIN_W, which is BIN_W edges after acceptance.
- Throughput: a new start during the done cycle is accepted. The back-to-back period is BIN_W+1 cycles.
- start while busy: ignored, no queueing; changes on bin while busy have no effect.
- Outputs bcd, ovf and blank hold their last value between done pulses.
- blank[i], for i≥1: 1 iff digit i and all digits above it equal 0. blank[0] is constant 0.
- Reset asserted mid-conversion:
  - the conversion is aborted with no done pulse;
  - outputs take their reset values;
  - after release, the FSM is in IDLE and accepts start.
- Width rules:
  - counter is wide enough for BIN_W;
  - digit adjust saturates nothing; digits are always ≤9 before each shift by construction.
- DIGITS sized too small for BIN_W is legal; overflow is then reported through ovf and saturation.

Test Plan:
- Defaults (BIN_W=14, DIGITS=4): start with bin=9999 -> done one cycle, 14 edges after acceptance; bcd=16'h9999, ovf=0, blank=4'b0000; busy high for 14 cycles.
- bin=305 -> bcd=16'h0305, blank=4'b1000, ovf=0. Then bin=0 -> bcd=16'h0000, blank=4'b1110.
- bin=10000 and bin=16383 -> bcd=16'h9999, ovf=1 each time. A following conversion of bin=42 -> bcd=16'h0042, ovf=0, blank=4'b1100.
- Pulse start again at cycles 3 and 10 of a conversion of 1234, changing bin to 77 -> single done; bcd=16'h1234.
- Assert start during the done cycle with bin=8 -> accepted; next done 14 edges later with bcd=16'h0008, blank=4'b1110.
- Drop rst_n for 1 cycle at cycle 6 of a conversion of 5000 -> busy, done, bcd and ovf go to 0 immediately and blank to 4'b1110, no done pulse. A fresh start with bin=5000 -> bcd=16'h5000.
- Exhaustive sweep with BIN_W=10, DIGITS=3: compare against a reference model for 0..1023, including ovf=1 and 0x999 for 1000..1023.
